// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic family.
// Holds the serial subtractor state encoding. Future serial adder and multiplier
// blocks reuse it.
package serial_arith_pkg;

    // IDLE : waiting for i_start
    // SHIFT: one operand bit pair processed per cycle, LSB first
    // DONE : result registers valid, o_done pulses
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } t_sub_state;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell (combinational). It is the subtract-side twin
// of the full_adder cell.
// Ports:
//   i_a          minuend bit
//   i_b          subtrahend bit
//   i_borrow_in  incoming borrow
//   o_d          difference bit
//   o_borrow_out outgoing borrow
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_borrow_in,
    output logic o_d,
    output logic o_borrow_out
);

    always_comb begin
        o_d          = i_a ^ i_b ^ i_borrow_in;
        // Borrow when b > a, or when a == b and a borrow is already pending.
        o_borrow_out = (~i_a & i_b) | (~(i_a ^ i_b) & i_borrow_in);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: computes (A - B - borrow_in) mod 2^W one bit
// per clock, LSB first, behind a start/done handshake.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_start             request, sampled only while idle
//   i_a, i_b            minuend / subtrahend, captured on accepted start
//   i_borrow_in         initial borrow, captured on accepted start
//   o_busy              high whenever not idle
//   o_done              one-cycle pulse when o_d / o_borrow_out are updated
//   o_d                 registered difference
//   o_borrow_out        registered final borrow (A < B + borrow_in, unsigned)
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_borrow_in,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_d,
    output logic         o_borrow_out
);

    localparam int unsigned CntW = $clog2(W + 1);
    // Counter value while the W-th (last) bit is being processed.
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    t_sub_state      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            br_q, br_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    d_q, d_d;
    logic            bout_q, bout_d;

    logic            fs_d;
    logic            fs_bout;
    logic [W-1:0]    res_shift;

    full_subtractor u_fs (
        .i_a          (a_q[0]),
        .i_b          (b_q[0]),
        .i_borrow_in  (br_q),
        .o_d          (fs_d),
        .o_borrow_out (fs_bout)
    );

    // New difference bit enters at the MSB, so after W shifts bit 0 sits at
    // the LSB. Written with shifts so W = 1 needs no special case.
    assign res_shift = (res_q >> 1) | (W'(fs_d) << (W - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        d_d     = d_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    br_d    = i_borrow_in;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = fs_bout;
                res_d = res_shift;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // Publish only the complete result; partials stay internal.
                    d_d     = res_shift;
                    bout_d  = fs_bout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
        end
    end

    assign o_busy       = (state_q != IDLE);
    assign o_done       = (state_q == DONE);
    assign o_d          = d_q;
    assign o_borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at W = 4.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         i_reset;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_borrow_in;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_d;
    logic         o_borrow_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.W(W)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_a          (i_a),
        .i_b          (i_b),
        .i_borrow_in  (i_borrow_in),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_d          (o_d),
        .o_borrow_out (o_borrow_out)
    );

    // Reference model: plain unsigned arithmetic.
    function automatic logic [W-1:0] ref_d(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        int r;
        r = int'(a) - int'(b) - int'(bin);
        if (r < 0) r = r + (1 << W);
        return W'(r);
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic bin);
        return (int'(a) < int'(b) + int'(bin));
    endfunction

    // Issue one operation from idle and observe it. Operands are scrambled
    // after acceptance. Latency counts negedges after acceptance (first one = 1).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          output int lat, output int busy_n, output int done_n,
                          output logic [W-1:0] d, output logic bout);
        @(negedge clk);
        i_start = 1'b1; i_a = a; i_b = b; i_borrow_in = bin;
        @(negedge clk);
        i_start = 1'b0;
        lat = 0; busy_n = 0; done_n = 0; d = '0; bout = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (o_busy) busy_n++;
            if (o_done) begin
                done_n++;
                if (lat == 0) lat = i;
                d = o_d; bout = o_borrow_out;
            end
            i_a = W'($urandom); i_b = W'($urandom); i_borrow_in = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0; i_borrow_in = 1'b0;
        #12;
        n_tests++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
        n_tests++;
        if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", o_done); end
        n_tests++;
        if (o_d !== '0) begin n_fail++; $display("FAIL reset_d got %h want 0", o_d); end
        n_tests++;
        if (o_borrow_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_bout got %b want 0", o_borrow_out);
        end
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, busy_n, done_n;
        logic [W-1:0] d;
        logic bout;
        run_op(4'd9, 4'd3, 1'b0, lat, busy_n, done_n, d, bout);
        n_tests++;
        if (lat !== 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", lat); end
        n_tests++;
        if (busy_n !== 5) begin n_fail++; $display("FAIL basic_busy got %0d want 5", busy_n); end
        n_tests++;
        if (done_n !== 1) begin n_fail++; $display("FAIL basic_done_cnt got %0d want 1", done_n); end
        n_tests++;
        if (d !== 4'd6 || bout !== 1'b0) begin
            n_fail++; $display("FAIL basic_9m3 got %h/%b want 6/0", d, bout);
        end
    endtask

    task automatic test_borrow();
        int lat, busy_n, done_n;
        logic [W-1:0] d;
        logic bout;
        run_op(4'd3, 4'd9, 1'b0, lat, busy_n, done_n, d, bout);
        n_tests++;
        if (d !== 4'hA || bout !== 1'b1) begin
            n_fail++; $display("FAIL borrow_3m9 got %h/%b want a/1", d, bout);
        end
        run_op(4'd7, 4'd7, 1'b0, lat, busy_n, done_n, d, bout);
        n_tests++;
        if (d !== 4'h0 || bout !== 1'b0) begin
            n_fail++; $display("FAIL borrow_7m7 got %h/%b want 0/0", d, bout);
        end
        run_op(4'd0, 4'd0, 1'b1, lat, busy_n, done_n, d, bout);
        n_tests++;
        if (d !== 4'hF || bout !== 1'b1) begin
            n_fail++; $display("FAIL borrow_0m0b1 got %h/%b want f/1", d, bout);
        end
    endtask

    task automatic test_random();
        int lat, busy_n, done_n;
        logic [W-1:0] d, a, b;
        logic bout, bin;
        for (int n = 0; n < 16; n++) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            run_op(a, b, bin, lat, busy_n, done_n, d, bout);
            n_tests++;
            if (d !== ref_d(a, b, bin) || bout !== ref_bout(a, b, bin) || lat !== 5) begin
                n_fail++;
                $display("FAIL random_%0h_%0h_%0b got %h/%b lat %0d want %h/%b lat 5",
                         a, b, bin, d, bout, lat, ref_d(a, b, bin), ref_bout(a, b, bin));
            end
        end
    endtask

    // Start pulses during SHIFT and during DONE must be ignored.
    task automatic test_ignore_start();
        int busy_n, done_n;
        logic [W-1:0] d;
        @(negedge clk);
        i_start = 1'b1; i_a = 4'd9; i_b = 4'd3; i_borrow_in = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        busy_n = 0; done_n = 0; d = '0;
        for (int i = 1; i <= 8; i++) begin
            if (o_busy) busy_n++;
            if (o_done) begin done_n++; d = o_d; end
            i_start = (i == 2 || i == 5);
            i_a = 4'd1; i_b = 4'd1;
            @(negedge clk);
        end
        n_tests++;
        if (done_n !== 1) begin n_fail++; $display("FAIL ignore_done_cnt got %0d want 1", done_n); end
        n_tests++;
        if (busy_n !== 5) begin n_fail++; $display("FAIL ignore_busy got %0d want 5", busy_n); end
        n_tests++;
        if (d !== 4'd6 || o_d !== 4'd6) begin
            n_fail++; $display("FAIL ignore_result got %h/%h want 6", d, o_d);
        end
    endtask

    task automatic test_async_reset();
        int lat, busy_n, done_n;
        logic [W-1:0] d;
        logic bout;
        @(negedge clk);
        i_start = 1'b1; i_a = 4'd12; i_b = 4'd5; i_borrow_in = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 i_reset = 1'b1;
        #1;
        n_tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_d !== '0 || o_borrow_out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got busy %b done %b d %h bout %b want all 0",
                     o_busy, o_done, o_d, o_borrow_out);
        end
        @(negedge clk);
        i_reset = 1'b0;
        done_n = 0; busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_done) done_n++;
            if (o_busy) busy_n++;
            @(negedge clk);
        end
        n_tests++;
        if (done_n !== 0 || busy_n !== 0) begin
            n_fail++; $display("FAIL async_no_done got done %0d busy %0d want 0/0", done_n, busy_n);
        end
        run_op(4'd5, 4'd2, 1'b0, lat, busy_n, done_n, d, bout);
        n_tests++;
        if (d !== 4'd3 || bout !== 1'b0 || lat !== 5) begin
            n_fail++; $display("FAIL async_after_5m2 got %h/%b lat %0d want 3/0 lat 5", d, bout, lat);
        end
    endtask

    // i_start held high: one acceptance every W+2 cycles, operands scrambled in
    // between, every (a, b, borrow_in) combination covered.
    task automatic test_back_to_back();
        localparam int Period = W + 2;
        localparam int NOps   = 512;
        logic [W-1:0] exp_d_q[$];
        logic         exp_b_q[$];
        logic [W-1:0] held_d, ed, a, b;
        logic         held_b, eb, have_res, bin;
        int           op;
        have_res = 1'b0; held_d = '0; held_b = 1'b0; op = 0;
        @(negedge clk);
        i_start = 1'b1;
        for (int c = 0; c <= NOps * Period; c++) begin
            if (c % Period == Period - 1) begin
                n_tests++;
                if (exp_d_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_model_empty at cycle %0d", c);
                end else begin
                    ed = exp_d_q.pop_front(); eb = exp_b_q.pop_front();
                    if (o_done !== 1'b1 || o_d !== ed || o_borrow_out !== eb) begin
                        n_fail++;
                        $display("FAIL b2b_result cycle %0d got done %b %h/%b want done 1 %h/%b",
                                 c, o_done, o_d, o_borrow_out, ed, eb);
                    end
                    held_d = ed; held_b = eb; have_res = 1'b1;
                end
            end else begin
                n_tests++;
                if (o_done !== 1'b0 || (have_res && (o_d !== held_d || o_borrow_out !== held_b)))
                begin
                    n_fail++;
                    $display("FAIL b2b_hold cycle %0d got done %b %h/%b want done 0 %h/%b",
                             c, o_done, o_d, o_borrow_out, held_d, held_b);
                end
            end
            if (c % Period == 0 && op < NOps) begin
                a = W'(op); b = W'(op >> 4); bin = 1'(op >> 8);
                exp_d_q.push_back(ref_d(a, b, bin));
                exp_b_q.push_back(ref_bout(a, b, bin));
                i_a = a; i_b = b; i_borrow_in = bin;
                op++;
            end else begin
                i_a = W'($urandom); i_b = W'($urandom); i_borrow_in = 1'($urandom);
            end
            if (c == NOps * Period - 1) i_start = 1'b0;
            @(negedge clk);
        end
        n_tests++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_final_idle got %b want 0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_random();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial W-bit subtractor computing A − B − borrow_in one bit per clock, LSB first, behind a start/done handshake. It is the sequential counterpart of the team's ripple-carry adder datapath. It is used wherever area matters more than latency, such as ALU experiments and shared arithmetic units. One full-subtractor cell plus a borrow flop replaces W combinational cells.

## Interface
- W, default 4, operand and result width in bits (W ≥ 1).
- i_clk  input  1  clock, all state updates on rising edge.
- i_reset  input  1  reset, asynchronous, active-high.
- i_start  input  1  request; sampled only in IDLE.
- i_a  input  W  minuend; captured on accepted start.
- i_b  input  W  subtrahend; captured on accepted start.
- i_borrow_in  input  1  initial borrow; captured on accepted start.
- o_busy  output  1  high whenever state ≠ IDLE.
- o_done  output  1  one-cycle pulse when the result becomes valid.
- o_d  output  W  difference (A − B − borrow_in) mod 2^W.
- o_borrow_out  output  1  final borrow: 1 iff A < B + borrow_in (unsigned).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, i_start = 1:
  - Load the operand shift registers with i_a and i_b.
  - Load the borrow flop with i_borrow_in.
  - Clear the bit counter; go to SHIFT.
- IDLE, i_start = 0: stay.
- SHIFT, each cycle, on the current LSBs a0, b0 and borrow br:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift d into the MSB of the working result register, shifting right.
  - Shift the operands right; increment the counter.
- SHIFT, after the W-th bit:
  - Copy the working result to o_d and br_next to o_borrow_out.
  - Go to DONE.
- DONE: o_done = 1 for exactly one cycle, then go to IDLE.
- o_d and o_borrow_out are registered. They change only on entry to DONE and hold until the next entry to DONE. Partial results are never visible.
- i_start is ignored in SHIFT and DONE. No queuing; a dropped request is the requester's problem, and it must watch o_busy.
- Operands are captured at start. Changing i_a, i_b or i_borrow_in afterwards has no effect on the running operation.
- Width rules:
  - Bit counter is $clog2(W+1) bits.
  - Arithmetic is unsigned modulo 2^W.
  - Signed overflow is not reported.

## Timing
- Reset (asynchronous, any state) forces:
  - state = IDLE.
  - o_busy = 0, o_done = 0.
  - o_d = 0, o_borrow_out = 0.
  - Counter, operand, borrow and working registers = 0.
- Reset mid-operation aborts with no o_done pulse.
- Start is accepted at edge k (state IDLE, i_start = 1). o_busy is high from after edge k.
- SHIFT occupies edges k+1 … k+W.
- o_done is high in the cycle after edge k+W, i.e. W+1 cycles after acceptance.
- Returns to IDLE at edge k+W+1.
- Minimum start-to-start spacing: W+2 cycles. With i_start held high, one operation is accepted every W+2 cycles.
- W = 1 is legal: one SHIFT cycle, done after 2 cycles.

## Structure
- Package serial_arith_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} t_sub_state.
  - Shared with future serial adder/multiplier blocks.
- Sub-module full_subtractor (i_a, i_b, i_borrow_in, o_d, o_borrow_out):
  - Purely combinational, one instance.
  - Mirrors the existing full_adder cell.
- Top level holds the FSM, counter, shift registers, borrow flop and output registers.

## Test plan
All cases use W = 4.
- 9 − 3, borrow_in 0, start at edge k → o_done high in the cycle after edge k+4; o_d = 6, o_borrow_out = 0; o_busy high for 5 cycles.
- 3 − 9, borrow_in 0 → o_d = 4'hA, o_borrow_out = 1. Then 7 − 7 → o_d = 0, o_borrow_out = 0.
- 0 − 0, borrow_in 1 → o_d = 4'hF, o_borrow_out = 1.
- Start 9 − 3, then pulse i_start with 1 − 1 during SHIFT and again in DONE → both ignored; only one o_done; result 6.
- Assert i_reset asynchronously after 2 SHIFT cycles → all outputs 0 immediately; state IDLE; no o_done. A subsequent 5 − 2 yields o_d = 3 with normal latency.
- i_start held high with changing operands → acceptances every 6 cycles; o_d holds each result until the next o_done; results match a reference model for all 512 (a, b, borrow_in) combinations.
